// File: rtl/cache_conj_pkg.sv
// Shared types and helpers for the set-associative cache: FSM state
// encoding, width helper and per-line status flags.
package cache_conj_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_REFILL,
    ST_RESPOND
  } state_t;

  // Width of the performance counters.
  localparam int STAT_W = 16;

  // Ceiling log2 used to derive INDEX_W and AGE_W from SETS and WAYS.
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Status bits of one cache line; tag, data and age live in their own arrays.
  typedef struct packed {
    logic valid;
    logic dirty;
  } line_flags_t;

endpackage

// File: rtl/cache_lru_ages.sv
// Combinational true-LRU helper for one set: produces the ages after
// touching one way, and picks a victim (lowest invalid way, else the oldest).
module cache_lru_ages
  import cache_conj_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int AGE_W = 1
) (
  input  logic [WAYS*AGE_W-1:0] ages,
  input  logic [WAYS-1:0]       valid,
  input  logic [AGE_W-1:0]      touch_way,
  output logic [WAYS*AGE_W-1:0] next_ages,
  output logic [AGE_W-1:0]      victim_way
);

  logic [AGE_W-1:0] age_arr [WAYS];
  logic [AGE_W-1:0] touched_age;
  logic             found;

  assign touched_age = age_arr[touch_way];

  // Ways younger than the touched one age by one; the touched way becomes newest.
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign age_arr[gi] = ages[gi*AGE_W +: AGE_W];
    assign next_ages[gi*AGE_W +: AGE_W] =
      (AGE_W'(gi) == touch_way)   ? '0 :
      (age_arr[gi] < touched_age) ? age_arr[gi] + 1'b1 :
                                    age_arr[gi];
  end

  // Victim selection: prefer an empty way, otherwise evict the least recently used.
  always_comb begin
    victim_way = '0;
    found      = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid[w]) begin
        victim_way = AGE_W'(w);
        found      = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_arr[w] == AGE_W'(WAYS - 1)) victim_way = AGE_W'(w);
      end
    end
  end

endmodule

// File: rtl/cache_conj_assoc.sv
// N-way set-associative write-back / write-allocate cache, one word per
// line, true-LRU replacement, blocking request and memory handshakes.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_conj_assoc
  import cache_conj_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int SETS   = 2,
  parameter int WAYS   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_valid,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_misses
);

  localparam int INDEX_W = log2_ceil(SETS);
  localparam int AGE_W   = log2_ceil(WAYS);
  localparam int TAG_W   = ADDR_W - INDEX_W;

  // Line storage
  line_flags_t       flags_reg [SETS][WAYS];
  logic [TAG_W-1:0]  tag_reg   [SETS][WAYS];
  logic [DATA_W-1:0] data_reg  [SETS][WAYS];
  logic [AGE_W-1:0]  age_reg   [SETS][WAYS];

  // Control and captured request
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              write_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [AGE_W-1:0]  victim_reg;

  // Registered outputs
  logic              resp_valid_reg, resp_hit_reg, mem_valid_reg, mem_write_reg;
  logic [DATA_W-1:0] resp_rdata_reg, mem_wdata_reg;
  logic [ADDR_W-1:0] mem_addr_reg;

  // Lookup datapath
  logic [INDEX_W-1:0]    index;
  logic [TAG_W-1:0]      tag;
  logic [WAYS-1:0]       way_hit, set_valid;
  logic [WAYS*AGE_W-1:0] set_ages, next_ages_flat;
  logic [AGE_W-1:0]      next_age [WAYS];
  logic [AGE_W-1:0]      hit_way, victim_way, touch_way;
  logic                  hit, lookup_hit, victim_dirty, wb_done, refill_done;
  logic [DATA_W-1:0]     fill_data;

  assign index = addr_reg[INDEX_W-1:0];
  assign tag   = addr_reg[ADDR_W-1:INDEX_W];

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
    assign way_hit[gi]   = flags_reg[index][gi].valid && (tag_reg[index][gi] == tag);
    assign set_valid[gi] = flags_reg[index][gi].valid;
    assign set_ages[gi*AGE_W +: AGE_W] = age_reg[index][gi];
    assign next_age[gi]  = next_ages_flat[gi*AGE_W +: AGE_W];
  end

  // Encode the matching way (at most one can match).
  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_way = AGE_W'(w);
    end
  end

  assign hit          = |way_hit;
  assign lookup_hit   = (state_reg == ST_LOOKUP) && hit;
  assign touch_way    = (state_reg == ST_LOOKUP) ? hit_way : victim_reg;
  assign victim_dirty = flags_reg[index][victim_way].valid && flags_reg[index][victim_way].dirty;
  assign wb_done      = (state_reg == ST_WRITEBACK) && mem_valid_reg && mem_ack;
  assign refill_done  = (state_reg == ST_REFILL) && mem_valid_reg && mem_ack;
  assign fill_data    = write_reg ? wdata_reg : mem_rdata;

  cache_lru_ages #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_lru (
    .ages       (set_ages),
    .valid      (set_valid),
    .touch_way  (touch_way),
    .next_ages  (next_ages_flat),
    .victim_way (victim_way)
  );

  // Next-state logic for the request FSM.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (req_valid) state_next = ST_LOOKUP;
      ST_LOOKUP: begin
        if (hit)               state_next = ST_RESPOND;
        else if (victim_dirty) state_next = ST_WRITEBACK;
        else                   state_next = ST_REFILL;
      end
      ST_WRITEBACK: if (wb_done)     state_next = ST_REFILL;
      ST_REFILL:    if (refill_done) state_next = ST_RESPOND;
      ST_RESPOND:   state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // FSM state, captured request and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      write_reg      <= 1'b0;
      wdata_reg      <= '0;
      victim_reg     <= '0;
      resp_valid_reg <= 1'b0;
      resp_hit_reg   <= 1'b0;
      resp_rdata_reg <= '0;
      mem_valid_reg  <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      resp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            addr_reg  <= req_addr;
            write_reg <= req_write;
            wdata_reg <= req_wdata;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            resp_valid_reg <= 1'b1;
            resp_hit_reg   <= 1'b1;
            resp_rdata_reg <= write_reg ? wdata_reg : data_reg[index][hit_way];
          end else begin
            victim_reg    <= victim_way;
            mem_valid_reg <= 1'b1;
            if (victim_dirty) begin
              mem_write_reg <= 1'b1;
              mem_addr_reg  <= {tag_reg[index][victim_way], index};
              mem_wdata_reg <= data_reg[index][victim_way];
            end else begin
              mem_write_reg <= 1'b0;
              mem_addr_reg  <= addr_reg;
            end
          end
        end
        ST_WRITEBACK: begin
          // Drop the request for one cycle before the refill is issued.
          if (wb_done) mem_valid_reg <= 1'b0;
        end
        ST_REFILL: begin
          if (!mem_valid_reg) begin
            mem_valid_reg <= 1'b1;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= addr_reg;
          end else if (mem_ack) begin
            mem_valid_reg  <= 1'b0;
            resp_valid_reg <= 1'b1;
            resp_hit_reg   <= 1'b0;
            resp_rdata_reg <= fill_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Line status and LRU ages; reset invalidates everything and restores age = way.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          flags_reg[s][w] <= '0;
          age_reg[s][w]   <= AGE_W'(w);
        end
      end
    end else if (lookup_hit) begin
      if (write_reg) flags_reg[index][hit_way].dirty <= 1'b1;
      for (int w = 0; w < WAYS; w++) age_reg[index][w] <= next_age[w];
    end else if (refill_done) begin
      flags_reg[index][victim_reg] <= '{valid: 1'b1, dirty: write_reg};
      for (int w = 0; w < WAYS; w++) age_reg[index][w] <= next_age[w];
    end
  end

  // Tag and data arrays need no reset; validity is tracked by the flags.
  always_ff @(posedge clock) begin
    if (lookup_hit && write_reg) begin
      data_reg[index][hit_way] <= wdata_reg;
    end else if (refill_done) begin
      tag_reg[index][victim_reg]  <= tag;
      data_reg[index][victim_reg] <= fill_data;
    end
  end

  assign req_ready  = (state_reg == ST_IDLE);
  assign resp_valid = resp_valid_reg;
  assign resp_hit   = resp_hit_reg;
  assign resp_rdata = resp_rdata_reg;
  assign mem_valid  = mem_valid_reg;
  assign mem_write  = mem_write_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;

`ifdef CACHE_STATS_EN
  logic [STAT_W-1:0] hits_reg, misses_reg;

  // Saturating hit/miss counters, stepped once per lookup.
  always_ff @(posedge clock) begin
    if (reset) begin
      hits_reg   <= '0;
      misses_reg <= '0;
    end else if (state_reg == ST_LOOKUP) begin
      if (hit && (hits_reg != '1))    hits_reg   <= hits_reg + 1'b1;
      if (!hit && (misses_reg != '1)) misses_reg <= misses_reg + 1'b1;
    end
  end

  assign stat_hits   = hits_reg;
  assign stat_misses = misses_reg;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_cache_conj_assoc.sv
// Self-checking bench for cache_conj_assoc (default parameters). The bench
// acts as backing memory and predicts every response with a recency-stamp
// cache model. Stats expectations follow CACHE_STATS_EN.
module tb_cache_conj_assoc;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_write, mem_ack;
  logic [4:0]  req_addr;
  logic [7:0]  req_wdata, mem_rdata;
  logic        req_ready, resp_valid, resp_hit, mem_valid, mem_write;
  logic [7:0]  resp_rdata, mem_wdata;
  logic [4:0]  mem_addr;
  logic [15:0] stat_hits, stat_misses;

  int total = 0;
  int bad   = 0;

  // Reference model: backing memory plus per-set lines with use timestamps.
  logic [7:0] mem_model [32];
  bit         m_valid [2][2];
  bit         m_dirty [2][2];
  logic [3:0] m_tag   [2][2];
  logic [7:0] m_data  [2][2];
  int         m_stamp [2][2];
  int         now_stamp = 0;
  int         exp_hits = 0;
  int         exp_misses = 0;

  cache_conj_assoc dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_hit    (resp_hit),
    .mem_valid   (mem_valid),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic chk_stats();
`ifdef CACHE_STATS_EN
    chk("stat_hits", {16'h0, stat_hits}, exp_hits);
    chk("stat_misses", {16'h0, stat_misses}, exp_misses);
`else
    chk("stat_hits", {16'h0, stat_hits}, 0);
    chk("stat_misses", {16'h0, stat_misses}, 0);
`endif
  endtask

  // One complete transaction: predict, drive, serve memory, check response.
  task automatic do_req(input bit wr, input logic [4:0] a, input logic [7:0] wd, input int delay);
    int         s, slot, cyc, phase_cnt, mem_cycles, wb_cnt, rf_cnt, oldest;
    bit         hit, exp_wb, got;
    logic [4:0] wb_addr;
    logic [7:0] wb_data, exp_data;
    s = int'(a[0]);
    hit = 0; slot = -1; exp_wb = 0; wb_addr = '0; wb_data = '0;
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_tag[s][w] == a[4:1]) begin hit = 1; slot = w; end
    if (!hit) begin
      for (int w = 0; w < 2; w++)
        if (!m_valid[s][w] && slot < 0) slot = w;
      if (slot < 0) begin
        oldest = 0;
        for (int w = 1; w < 2; w++)
          if (m_stamp[s][w] < m_stamp[s][oldest]) oldest = w;
        slot = oldest;
        if (m_dirty[s][slot]) begin
          exp_wb  = 1;
          wb_addr = {m_tag[s][slot], a[0]};
          wb_data = m_data[s][slot];
        end
      end
    end
    exp_data = wr ? wd : (hit ? m_data[s][slot] : mem_model[a]);

    @(negedge clock);
    chk("idle_ready", {31'h0, req_ready}, 1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    @(posedge clock);
    #1 req_valid = 1'b0;
    cyc = 0; got = 0; phase_cnt = 0; mem_cycles = 0; wb_cnt = 0; rf_cnt = 0;
    while (!got && cyc < 100) begin
      @(negedge clock);
      cyc++;
      mem_ack = 1'b0;
      if (resp_valid) begin
        got = 1;
        chk("resp_hit", {31'h0, resp_hit}, {31'h0, hit});
        chk("resp_rdata", {24'h0, resp_rdata}, {24'h0, exp_data});
        chk("wb_count", wb_cnt, {31'h0, exp_wb});
        chk("refill_count", rf_cnt, hit ? 0 : 1);
        if (hit) begin
          chk("hit_latency", cyc, 2);
          chk("hit_mem_idle", mem_cycles, 0);
        end
      end else if (mem_valid) begin
        mem_cycles++;
        chk("busy_ready", {31'h0, req_ready}, 0);
        if (mem_write) begin
          chk("wb_addr", {27'h0, mem_addr}, {27'h0, wb_addr});
          chk("wb_data", {24'h0, mem_wdata}, {24'h0, wb_data});
          mem_model[mem_addr] = mem_wdata;
          mem_ack = 1'b1;
          wb_cnt++;
        end else begin
          chk("refill_addr", {27'h0, mem_addr}, {27'h0, a});
          if (phase_cnt == delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_model[a];
            rf_cnt++;
            phase_cnt = 0;
          end else begin
            phase_cnt++;
          end
        end
      end
    end
    if (!got) chk("resp_timeout", 0, 1);
    mem_ack = 1'b0;
    @(negedge clock);
    chk("resp_single", {31'h0, resp_valid}, 0);
    $display("req %s addr=%02h wdata=%02h hit=%0d rdata=%02h exp=%02h", wr ? "W" : "R", a, wd, resp_hit, resp_rdata, exp_data);

    m_valid[s][slot] = 1;
    m_tag[s][slot]   = a[4:1];
    m_data[s][slot]  = exp_data;
    m_dirty[s][slot] = hit ? (m_dirty[s][slot] | wr) : wr;
    m_stamp[s][slot] = ++now_stamp;
    if (hit) exp_hits++; else exp_misses++;
  endtask

  initial begin
    bit found;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 32; i++) mem_model[i] = 8'($urandom);
    mem_model[4] = 8'hA5;
    mem_model[3] = 8'h77;
    model_clear();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Reset values
    chk("rst_ready", {31'h0, req_ready}, 1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 0);
    chk("rst_resp_hit", {31'h0, resp_hit}, 0);
    chk("rst_resp_rdata", {24'h0, resp_rdata}, 0);
    chk("rst_mem_valid", {31'h0, mem_valid}, 0);
    chk("rst_mem_write", {31'h0, mem_write}, 0);
    chk("rst_mem_addr", {27'h0, mem_addr}, 0);
    chk("rst_mem_wdata", {24'h0, mem_wdata}, 0);
    chk_stats();

    // Directed sequence
    do_req(0, 5'h04, 8'h00, 0);   // miss, refill A5
    do_req(0, 5'h04, 8'h00, 0);   // hit
    do_req(1, 5'h04, 8'h3C, 0);   // write hit
    do_req(0, 5'h06, 8'h00, 0);   // miss into second way
    do_req(0, 5'h08, 8'h00, 0);   // evicts dirty 0x04
    chk("wb_landed", {24'h0, mem_model[4]}, 32'h3C);
    do_req(1, 5'h03, 8'h11, 0);   // write miss, resp = 0x11
    do_req(0, 5'h03, 8'h00, 0);   // hit 0x11
    do_req(0, 5'h0A, 8'h00, 5);   // slow refill
    chk_stats();

    // Reset during REFILL
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h1B; req_wdata = '0;
    @(posedge clock);
    #1 req_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock);
      mem_ack = 1'b0;
      if (mem_valid && mem_write) begin
        mem_model[mem_addr] = mem_wdata;
        mem_ack = 1'b1;
      end else if (mem_valid) begin
        found = 1;
      end
    end
    chk("reach_refill", {31'h0, found}, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rstmid_mem_valid", {31'h0, mem_valid}, 0);
    chk("rstmid_ready", {31'h0, req_ready}, 1);
    chk("rstmid_resp", {31'h0, resp_valid}, 0);
    model_clear();
    chk_stats();
    begin
      int resp_seen;
      resp_seen = 0;
      repeat (4) begin
        @(negedge clock);
        if (resp_valid) resp_seen++;
      end
      chk("rstmid_no_resp", resp_seen, 0);
    end
    $display("reset during refill: mem_valid=%0d req_ready=%0d", mem_valid, req_ready);

    // Stats: miss, hit, hit, miss
    do_req(0, 5'h04, 8'h00, 0);
    do_req(0, 5'h04, 8'h00, 0);
    do_req(0, 5'h04, 8'h00, 0);
    do_req(0, 5'h05, 8'h00, 0);
    chk_stats();

    // Random traffic over a small address range to mix hits, misses, writebacks
    for (int n = 0; n < 150; n++) begin
      logic [4:0] ra;
      ra = 5'($urandom_range(0, 11));
      do_req(1'($urandom), ra, 8'($urandom), int'($urandom_range(0, 3)));
    end
    chk_stats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if the run somehow stalls.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
